// File: rtl/mem_stage.sv
// MEM stage: owns the stack pointer, drives the data-memory port and sequences
// 16-bit and two-cycle 32-bit (PC / flags) accesses, then registers the MEM/WB boundary.
module mem_stage #(
  parameter logic [31:0] SP_RESET = 32'h000F_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_in,
  input  logic [15:0] Rdst1_val_in,
  input  logic [15:0] Rdst2_val_in,
  input  logic [15:0] Rsrc_val_in,
  input  logic [15:0] Rdst_val_in,
  input  logic [2:0]  Rdst1_in,
  input  logic [2:0]  Rdst2_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_type_in,
  input  logic        memToReg_in,
  input  logic        reglow_write_in,
  input  logic        reghigh_write_in,
  input  logic [1:0]  SP_src_in,
  input  logic        mem_addr_src_in,
  input  logic        mem_data_src_in,
  input  logic        PC_push_pop_in,
  input  logic        flags_push_pop_in,
  input  logic [15:0] mem_rdata_in,
  output logic [31:0] mem_addr_out,
  output logic [15:0] mem_wdata_out,
  output logic        mem_we_out,
  output logic        stall_out,
  output logic        stall_CCR_POP_out,
  output logic [3:0]  POP_flags_val_out,
  output logic        is_POP_flags_out,
  output logic [15:0] Rdst1_DATA_val_out,
  output logic [15:0] Rdst2_val_out,
  output logic [2:0]  Rdst1_out,
  output logic [2:0]  Rdst2_out,
  output logic        reglow_write_out,
  output logic        reghigh_write_out,
  output logic [31:0] ret_addr_out,
  output logic        do_ret_out
);
  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state, state_nxt;
  logic [31:0] sp, sp_nxt, stack_addr, dw_data;
  logic [15:0] lo_hold, wb_data;
  logic        access, rd, dword, push, pop, bubble, ret_now;

  assign access  = mem_read_in | mem_write_in;
  assign rd      = mem_read_in & ~mem_write_in;  // write wins over read
  assign dword   = access & mem_type_in;
  assign push    = (SP_src_in == 2'b01);
  assign pop     = (SP_src_in == 2'b10);
  assign dw_data = PC_push_pop_in ? PC_in : {Rdst_val_in, Rsrc_val_in};
  assign ret_now = (state == SECOND) & rd & PC_push_pop_in;
  assign wb_data = (memToReg_in & rd) ? mem_rdata_in : Rdst1_val_in;

  always_comb begin
    state_nxt         = state;
    sp_nxt            = sp;
    stack_addr        = sp;
    mem_wdata_out     = mem_data_src_in ? Rdst_val_in : Rsrc_val_in;
    stall_out         = 1'b0;
    stall_CCR_POP_out = 1'b0;
    is_POP_flags_out  = 1'b0;
    bubble            = 1'b0;
    case (state)
      IDLE: begin
        if (pop) stack_addr = sp + 32'd1;
        if (dword) begin
          // High half first; SP moves once, at the end of the second cycle.
          state_nxt         = SECOND;
          stall_out         = 1'b1;
          bubble            = 1'b1;
          stall_CCR_POP_out = rd & flags_push_pop_in;
          mem_wdata_out     = dw_data[31:16];
        end else if (access) begin
          if (push)     sp_nxt = sp - 32'd1;
          else if (pop) sp_nxt = sp + 32'd1;
        end
      end
      SECOND: begin
        state_nxt        = IDLE;
        mem_wdata_out    = dw_data[15:0];
        is_POP_flags_out = rd & flags_push_pop_in;
        if (push) begin
          stack_addr = sp - 32'd1;
          sp_nxt     = sp - 32'd2;
        end else if (pop) begin
          stack_addr = sp + 32'd2;
          sp_nxt     = sp + 32'd2;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr_out      = mem_addr_src_in ? stack_addr
                           : ({16'b0, Rsrc_val_in} + {31'b0, state == SECOND});
  assign mem_we_out        = mem_write_in;
  assign POP_flags_val_out = mem_rdata_in[15:12];

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      sp                 <= SP_RESET;
      lo_hold            <= '0;
      Rdst1_DATA_val_out <= '0;
      Rdst2_val_out      <= '0;
      Rdst1_out          <= '0;
      Rdst2_out          <= '0;
      reglow_write_out   <= 1'b0;
      reghigh_write_out  <= 1'b0;
      ret_addr_out       <= '0;
      do_ret_out         <= 1'b0;
    end else begin
      state              <= state_nxt;
      sp                 <= sp_nxt;
      if (state == IDLE && dword && rd) lo_hold <= mem_rdata_in;
      Rdst1_DATA_val_out <= wb_data;
      Rdst2_val_out      <= Rdst2_val_in;
      Rdst1_out          <= Rdst1_in;
      Rdst2_out          <= Rdst2_in;
      reglow_write_out   <= reglow_write_in & ~bubble;
      reghigh_write_out  <= reghigh_write_in & ~bubble;
      do_ret_out         <= ret_now;
      if (ret_now) ret_addr_out <= {4'b0, mem_rdata_in[11:0], lo_hold};
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus queues cycle-tagged expectations,
// a negedge monitor compares those due in the current cycle.
module tb_mem_stage;
  logic        clk = 0, reset;
  logic [31:0] PC_in;
  logic [15:0] Rdst1_val_in, Rdst2_val_in, Rsrc_val_in, Rdst_val_in, mem_rdata_in;
  logic [2:0]  Rdst1_in, Rdst2_in;
  logic        mem_read_in, mem_write_in, mem_type_in, memToReg_in;
  logic        reglow_write_in, reghigh_write_in, mem_addr_src_in, mem_data_src_in;
  logic        PC_push_pop_in, flags_push_pop_in;
  logic [1:0]  SP_src_in;
  logic [31:0] mem_addr_out, ret_addr_out;
  logic [15:0] mem_wdata_out, Rdst1_DATA_val_out, Rdst2_val_out;
  logic        mem_we_out, stall_out, stall_CCR_POP_out, is_POP_flags_out;
  logic [3:0]  POP_flags_val_out;
  logic [2:0]  Rdst1_out, Rdst2_out;
  logic        reglow_write_out, reghigh_write_out, do_ret_out;

  mem_stage dut (
    .clk(clk), .reset(reset), .PC_in(PC_in),
    .Rdst1_val_in(Rdst1_val_in), .Rdst2_val_in(Rdst2_val_in),
    .Rsrc_val_in(Rsrc_val_in), .Rdst_val_in(Rdst_val_in),
    .Rdst1_in(Rdst1_in), .Rdst2_in(Rdst2_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_type_in(mem_type_in),
    .memToReg_in(memToReg_in), .reglow_write_in(reglow_write_in),
    .reghigh_write_in(reghigh_write_in), .SP_src_in(SP_src_in),
    .mem_addr_src_in(mem_addr_src_in), .mem_data_src_in(mem_data_src_in),
    .PC_push_pop_in(PC_push_pop_in), .flags_push_pop_in(flags_push_pop_in),
    .mem_rdata_in(mem_rdata_in), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_we_out(mem_we_out), .stall_out(stall_out),
    .stall_CCR_POP_out(stall_CCR_POP_out), .POP_flags_val_out(POP_flags_val_out),
    .is_POP_flags_out(is_POP_flags_out), .Rdst1_DATA_val_out(Rdst1_DATA_val_out),
    .Rdst2_val_out(Rdst2_val_out), .Rdst1_out(Rdst1_out), .Rdst2_out(Rdst2_out),
    .reglow_write_out(reglow_write_out), .reghigh_write_out(reghigh_write_out),
    .ret_addr_out(ret_addr_out), .do_ret_out(do_ret_out)
  );

  always #5 clk = ~clk;

  // Small data memory: combinational read, write on the clock edge.
  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0;
  assign mem_rdata_in = mem[mem_addr_out[7:0]];
  always @(posedge clk) if (mem_we_out) mem[mem_addr_out[7:0]] <= mem_wdata_out;

  typedef enum int {S_ADDR, S_WDATA, S_WE, S_STALL, S_CCR, S_FLAGS, S_ISF, S_WBDATA,
                    S_RDST1, S_RLOW, S_RET, S_DORET, S_SP, S_STATE} sel_t;
  typedef struct { int cyc; sel_t sel; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int cyc = 0, n_vec = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(sel_t s);
    case (s)
      S_ADDR:   return mem_addr_out;
      S_WDATA:  return {16'b0, mem_wdata_out};
      S_WE:     return {31'b0, mem_we_out};
      S_STALL:  return {31'b0, stall_out};
      S_CCR:    return {31'b0, stall_CCR_POP_out};
      S_FLAGS:  return {28'b0, POP_flags_val_out};
      S_ISF:    return {31'b0, is_POP_flags_out};
      S_WBDATA: return {16'b0, Rdst1_DATA_val_out};
      S_RDST1:  return {29'b0, Rdst1_out};
      S_RLOW:   return {31'b0, reglow_write_out};
      S_RET:    return ret_addr_out;
      S_DORET:  return {31'b0, do_ret_out};
      S_SP:     return dut.sp;
      default:  return {31'b0, dut.state};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t keep[$];
    logic [31:0] act;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        act = probe(sb[i].sel);
        n_vec++;
        if (act !== sb[i].val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].sel.name(), cyc, act, sb[i].val);
        end
      end else if (sb[i].cyc < cyc) begin
        n_err++;
        $display("FAIL %s expectation for cyc=%0d never checked", sb[i].sel.name(), sb[i].cyc);
      end else keep.push_back(sb[i]);
    end
    sb = keep;
  end

  task automatic expect_at(int ofs, sel_t s, logic [31:0] v);
    exp_t e;
    e.cyc = cyc + ofs; e.sel = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    PC_in = '0; Rdst1_val_in = '0; Rdst2_val_in = '0; Rsrc_val_in = '0; Rdst_val_in = '0;
    Rdst1_in = '0; Rdst2_in = '0; mem_read_in = 0; mem_write_in = 0; mem_type_in = 0;
    memToReg_in = 0; reglow_write_in = 0; reghigh_write_in = 0; SP_src_in = 2'b00;
    mem_addr_src_in = 0; mem_data_src_in = 0; PC_push_pop_in = 0; flags_push_pop_in = 0;
  endtask

  initial begin
    idle_in();
    reset = 1;
    step(); step();
    expect_at(0, S_SP, 32'h000F_FFFF); expect_at(0, S_RLOW, 0);
    expect_at(0, S_DORET, 0); expect_at(0, S_STALL, 0); expect_at(0, S_ISF, 0);
    reset = 0;
    step();

    // 16-bit push of BEEF
    mem_write_in = 1; mem_addr_src_in = 1; SP_src_in = 2'b01; Rsrc_val_in = 16'hBEEF;
    expect_at(0, S_ADDR, 32'h000F_FFFF); expect_at(0, S_WDATA, 16'hBEEF);
    expect_at(0, S_WE, 1); expect_at(0, S_STALL, 0); expect_at(1, S_SP, 32'h000F_FFFE);
    step();

    // 16-bit pop into R3
    idle_in();
    mem_read_in = 1; mem_addr_src_in = 1; SP_src_in = 2'b10; memToReg_in = 1;
    reglow_write_in = 1; Rdst1_in = 3'd3; Rdst1_val_in = 16'h1111;
    expect_at(0, S_ADDR, 32'h000F_FFFF); expect_at(0, S_WE, 0);
    expect_at(1, S_WBDATA, 16'hBEEF); expect_at(1, S_RDST1, 3); expect_at(1, S_RLOW, 1);
    expect_at(1, S_SP, 32'h000F_FFFF);
    step();

    // 32-bit PC push
    idle_in();
    mem_write_in = 1; mem_type_in = 1; PC_push_pop_in = 1; PC_in = 32'hA000_1234;
    SP_src_in = 2'b01; mem_addr_src_in = 1; reglow_write_in = 1;
    expect_at(0, S_ADDR, 32'h000F_FFFF); expect_at(0, S_WDATA, 16'hA000);
    expect_at(0, S_WE, 1); expect_at(0, S_STALL, 1);
    expect_at(1, S_RLOW, 0); expect_at(1, S_ADDR, 32'h000F_FFFE);
    expect_at(1, S_WDATA, 16'h1234); expect_at(1, S_WE, 1); expect_at(1, S_STALL, 0);
    expect_at(1, S_SP, 32'h000F_FFFF);
    expect_at(2, S_SP, 32'h000F_FFFD); expect_at(2, S_RLOW, 1);
    step(); step();

    // 32-bit PC+flags pop, issued back-to-back with the push
    idle_in();
    mem_read_in = 1; mem_type_in = 1; PC_push_pop_in = 1; flags_push_pop_in = 1;
    SP_src_in = 2'b10; mem_addr_src_in = 1;
    expect_at(0, S_ADDR, 32'h000F_FFFE); expect_at(0, S_CCR, 1);
    expect_at(0, S_STALL, 1); expect_at(0, S_ISF, 0);
    expect_at(1, S_ADDR, 32'h000F_FFFF); expect_at(1, S_ISF, 1); expect_at(1, S_FLAGS, 4'hA);
    expect_at(1, S_CCR, 0); expect_at(1, S_STALL, 0); expect_at(1, S_DORET, 0);
    expect_at(2, S_DORET, 1); expect_at(2, S_RET, 32'h0000_1234); expect_at(2, S_SP, 32'h000F_FFFF);
    expect_at(3, S_DORET, 0);
    step(); step();
    idle_in();
    step();

    // Non-stack store
    mem_write_in = 1; Rsrc_val_in = 16'h0040; mem_data_src_in = 1; Rdst_val_in = 16'h5555;
    expect_at(0, S_ADDR, 32'h0000_0040); expect_at(0, S_WDATA, 16'h5555); expect_at(0, S_WE, 1);
    expect_at(1, S_SP, 32'h000F_FFFF);
    step();

    // Push one word so SP differs from reset, then abort a PC pop in SECOND
    idle_in();
    mem_write_in = 1; mem_addr_src_in = 1; SP_src_in = 2'b01; Rsrc_val_in = 16'h7777;
    expect_at(1, S_SP, 32'h000F_FFFE);
    step();
    idle_in();
    mem_read_in = 1; mem_type_in = 1; PC_push_pop_in = 1; SP_src_in = 2'b10; mem_addr_src_in = 1;
    expect_at(0, S_STALL, 1); expect_at(1, S_STATE, 1);
    step();
    reset = 1;
    step();
    reset = 0; idle_in();
    expect_at(0, S_DORET, 0); expect_at(0, S_SP, 32'h000F_FFFF);
    expect_at(0, S_STATE, 0); expect_at(0, S_STALL, 0); expect_at(1, S_DORET, 0);
    step(); step(); step();

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL pending %0d expectations left unchecked", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end
endmodule
